// File: rtl/penc_pkg.sv
// penc_pkg: shared defaults, priority-select constants and code-width helper for the priority encoder
package penc_pkg;
    localparam int DEF_N     = 8;
    localparam int DEF_CNT_W = 16;
    localparam bit PRIO_MSB  = 1'b1;
    localparam bit PRIO_LSB  = 1'b0;

    function automatic int calc_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/penc_comb.sv
// penc_comb: combinational N-to-log2(N) priority encoder with zero flag (multi flag under PENC_MULTIHOT_ERR_EN)
module penc_comb
    import penc_pkg::*;
#(
    parameter int N        = DEF_N,
    parameter bit MSB_PRIO = PRIO_MSB,
    localparam int W       = calc_w(N)
) (
    input  logic [N-1:0] req,
    output logic [W-1:0] code,
    output logic         zero
`ifdef PENC_MULTIHOT_ERR_EN
    ,
    output logic         multi
`endif
);
    // later loop iterations override earlier ones, so scan order decides the winner
    always_comb begin
        code = '0;
        if (MSB_PRIO) begin
            for (int i = 0; i < N; i++)
                if (req[i]) code = W'(i);
        end else begin
            for (int i = N - 1; i >= 0; i--)
                if (req[i]) code = W'(i);
        end
    end

    assign zero = ~|req;

`ifdef PENC_MULTIHOT_ERR_EN
    assign multi = |(req & (req - N'(1)));
`endif
endmodule

// File: rtl/prio_encoder_pipe.sv
// prio_encoder_pipe: registered priority encoder with valid/ready and saturating word counter (optional PENC_MULTIHOT_ERR_EN adds err/err_cnt)
module prio_encoder_pipe
    import penc_pkg::*;
#(
    parameter int N        = DEF_N,
    parameter bit MSB_PRIO = PRIO_MSB,
    parameter int CNT_W    = DEF_CNT_W,
    localparam int W       = calc_w(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     req,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     code,
    output logic             zero,
    output logic [CNT_W-1:0] enc_cnt
`ifdef PENC_MULTIHOT_ERR_EN
    ,
    output logic             err,
    output logic [CNT_W-1:0] err_cnt
`endif
);
    logic [W-1:0] c_code;
    logic         c_zero;
    logic         accept;

`ifdef PENC_MULTIHOT_ERR_EN
    logic c_multi;
    penc_comb #(.N(N), .MSB_PRIO(MSB_PRIO)) u_comb (.req(req), .code(c_code), .zero(c_zero), .multi(c_multi));
`else
    penc_comb #(.N(N), .MSB_PRIO(MSB_PRIO)) u_comb (.req(req), .code(c_code), .zero(c_zero));
`endif

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    // output register: load on accept, hold under backpressure, drop valid on drain
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            code      <= '0;
            zero      <= 1'b0;
            enc_cnt   <= '0;
        end else begin
            out_valid <= accept || (out_valid && !out_ready);
            if (accept) begin
                code <= c_code;
                zero <= c_zero;
            end
            if (accept && enc_cnt != '1) enc_cnt <= enc_cnt + CNT_W'(1);
        end
    end

`ifdef PENC_MULTIHOT_ERR_EN
    // multi-hot flag travels with code; its counter saturates like enc_cnt
    always_ff @(posedge clk) begin
        if (rst) begin
            err     <= 1'b0;
            err_cnt <= '0;
        end else if (accept) begin
            err <= c_multi;
            if (c_multi && err_cnt != '1) err_cnt <= err_cnt + CNT_W'(1);
        end
    end
`endif
endmodule

// File: tb/tb_prio_encoder_pipe.sv
// tb_prio_encoder_pipe: randomized self-checking bench against a behavioural model (set PENC_MULTIHOT_ERR_EN to cover err/err_cnt)
module tb_prio_encoder_pipe;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] req = '0;

    logic        in_ready, out_valid, zero;
    logic [2:0]  code;
    logic [15:0] enc_cnt;
    logic        l_in_ready, l_out_valid, l_zero;
    logic [2:0]  l_code;
    logic [15:0] l_enc_cnt;
    logic        s_in_ready, s_out_valid, s_zero;
    logic [2:0]  s_code;
    logic [3:0]  s_enc_cnt;
`ifdef PENC_MULTIHOT_ERR_EN
    logic        err, l_err, s_err;
    logic [15:0] err_cnt, l_err_cnt;
    logic [3:0]  s_err_cnt;
`endif

    always #5 clk = ~clk;

    prio_encoder_pipe #(.N(8), .MSB_PRIO(1'b1), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .req(req),
        .out_valid(out_valid), .out_ready(out_ready), .code(code), .zero(zero), .enc_cnt(enc_cnt)
`ifdef PENC_MULTIHOT_ERR_EN
        , .err(err), .err_cnt(err_cnt)
`endif
    );

    prio_encoder_pipe #(.N(8), .MSB_PRIO(1'b0), .CNT_W(16)) dut_lsb (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(l_in_ready), .req(req),
        .out_valid(l_out_valid), .out_ready(out_ready), .code(l_code), .zero(l_zero), .enc_cnt(l_enc_cnt)
`ifdef PENC_MULTIHOT_ERR_EN
        , .err(l_err), .err_cnt(l_err_cnt)
`endif
    );

    prio_encoder_pipe #(.N(8), .MSB_PRIO(1'b1), .CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready), .req(req),
        .out_valid(s_out_valid), .out_ready(out_ready), .code(s_code), .zero(s_zero), .enc_cnt(s_enc_cnt)
`ifdef PENC_MULTIHOT_ERR_EN
        , .err(s_err), .err_cnt(s_err_cnt)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    // model state: what the output register should hold
    bit exp_valid = 1'b0;
    int exp_msb   = 0;
    int exp_lsb   = 0;
    bit exp_zero  = 1'b0;
    bit exp_err   = 1'b0;
    int words     = 0;
    int multis    = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int msb_idx(input int v);
        int i = 0;
        while (v > 1) begin
            v = v >> 1;
            i++;
        end
        return i;
    endfunction

    function automatic int lsb_idx(input int v);
        return (v == 0) ? 0 : msb_idx(v & (-v));
    endfunction

    function automatic int sat(input int v, input int lim);
        return (v > lim) ? lim : v;
    endfunction

    task automatic step(input bit v, input logic [7:0] r, input bit ordy);
        bit ready_exp, acc;
        in_valid  = v;
        req       = r;
        out_ready = ordy;
        #1;
        ready_exp = !exp_valid || ordy;
        if (!rst) begin
            chk("in_ready", in_ready, ready_exp);
            chk("l_in_ready", l_in_ready, ready_exp);
            chk("s_in_ready", s_in_ready, ready_exp);
        end
        acc = v && ready_exp;
        @(posedge clk);
        if (rst) begin
            exp_valid = 0; exp_msb = 0; exp_lsb = 0; exp_zero = 0; exp_err = 0;
            words = 0; multis = 0;
        end else begin
            exp_valid = acc || (exp_valid && !ordy);
            if (acc) begin
                exp_msb  = msb_idx(int'(r));
                exp_lsb  = lsb_idx(int'(r));
                exp_zero = (r == 0);
                exp_err  = $countones(r) > 1;
                words++;
                if (exp_err) multis++;
            end
        end
        #1;
        chk("out_valid", out_valid, exp_valid);
        chk("l_out_valid", l_out_valid, exp_valid);
        chk("s_out_valid", s_out_valid, exp_valid);
        chk("code_msb", code, exp_msb);
        chk("code_lsb", l_code, exp_lsb);
        chk("zero", zero, exp_zero);
        chk("l_zero", l_zero, exp_zero);
        chk("enc_cnt", enc_cnt, sat(words, 65535));
        chk("sat_cnt", s_enc_cnt, sat(words, 15));
`ifdef PENC_MULTIHOT_ERR_EN
        chk("err", err, exp_err);
        chk("err_cnt", err_cnt, sat(multis, 65535));
        chk("s_err_cnt", s_err_cnt, sat(multis, 15));
`endif
    endtask

    initial begin
        rst = 1'b1;
        step(1, 8'hFF, 1);
        step(1, 8'hFF, 1);
        rst = 1'b0;
        step(1, 8'b0010_1100, 1);
        step(1, 8'b0000_0001, 1);
        step(1, 8'h00, 1);
        step(1, 8'h80, 1);
        step(1, 8'h01, 0);
        step(1, 8'h02, 0);
        step(1, 8'h03, 0);
        step(1, 8'h04, 1);
        step(0, 8'hFF, 1);
        step(0, 8'h55, 1);
        step(1, 8'h18, 1);
        step(1, 8'h10, 1);
        step(1, 8'h18, 0);
        step(1, 8'h01, 0);
        rst = 1'b1;
        step(1, 8'h01, 0);
        rst = 1'b0;
        step(0, 8'h00, 1);
        for (int i = 0; i < 20; i++) step(1, 8'($urandom), 1);
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 3) != 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/prio_encoder_pipe.md
Name: prio_encoder_pipe

Overview:
- Registered N-to-log2(N) priority encoder with valid/ready flow control.
- It is the encode direction for the team's decoder/demux gate blocks: it accepts a request vector and returns the index of the highest-priority set bit plus a zero flag.
- It sits between request sources (arbiters, interrupt lines) and downstream index consumers.
- It also keeps a saturating count of encoded words for debug.

Parameters:
- N, 8, number of request inputs (power of two, 2..64).
- W, $clog2(N), width of the code output (derived, not overridden).
- MSB_PRIO, 1, 1 = highest index wins; 0 = lowest index wins.
- CNT_W, 16, width of the accepted-word counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  req is valid this cycle.
- in_ready  out  1  block can accept req this cycle.
- req  in  N  request vector.
- out_valid  out  1  code/zero are valid.
- out_ready  in  1  consumer accepts this cycle.
- code  out  W  index of the winning set bit.
- zero  out  1  req was all-zero (code = 0).
- enc_cnt  out  CNT_W  number of words accepted since reset, saturating.

Behaviour:
- Reset (rst=1 at posedge): out_valid=0, code=0, zero=0, enc_cnt=0. in_ready is combinational and is 1 after reset.
- Single output register stage. in_ready = !out_valid || out_ready; this is a combinational path from out_ready.
- Accept: in_valid && in_ready at posedge. On accept:
  - code and zero are loaded from the encoded req.
  - out_valid is set to 1.
  - enc_cnt increments, saturating at 2^CNT_W-1.
- Latency: exactly 1 cycle from accept to out_valid. Back-to-back throughput is 1 word per cycle while out_ready=1.
- Hold: out_valid && !out_ready leaves code and zero stable, and in_ready=0.
- Drain: out_valid && out_ready && !in_valid clears out_valid to 0 next cycle; code and zero keep their last values.
- Simultaneous drain and accept: the output register is overwritten with the new word and out_valid stays 1.
- Encoding:
  - MSB_PRIO=1: code = largest i with req[i]=1.
  - MSB_PRIO=0: code = smallest i with req[i]=1.
  - req=0: zero=1 and code=0. This is a legal word and is still counted.
- Inputs are sampled only on an accept; req may change freely otherwise.
- Reset mid-transfer: a held output word is discarded (out_valid=0) and the counter clears.
- Saturation: enc_cnt holds at all-ones and never wraps.
- No X propagation: code is fully defined for every req.

Optional Feature:
- Macro: PENC_MULTIHOT_ERR_EN.
- Defined:
  - Adds output port err (1 bit). It is registered alongside code and is 1 when the accepted req had more than one bit set.
  - Adds output port err_cnt (CNT_W bits), a saturating count of multi-hot words, reset to 0.
  - err resets to 0 and holds with code under backpressure.
- Not defined:
  - err and err_cnt do not exist.
  - Multi-hot inputs are encoded silently per priority.

Decomposition:
- Package penc_pkg holds:
  - Default N and CNT_W localparams.
  - Priority-select constants PRIO_MSB=1 and PRIO_LSB=0.
  - A function to compute W from N.
- One sub-module, penc_comb. It is purely combinational, parameterised by N and MSB_PRIO, and produces code, zero and (when PENC_MULTIHOT_ERR_EN is defined) multi.
- prio_encoder_pipe instantiates penc_comb and owns:
  - the handshake,
  - the output register,
  - the counters.

Test Plan:
- Reset/idle: assert rst for 2 cycles with in_valid=1 -> out_valid=0, enc_cnt=0, in_ready=1 after release.
- Priority select, MSB_PRIO=1, N=8, out_ready=1:
  - req=8'b0010_1100 -> next cycle code=5, zero=0.
  - req=8'b0000_0001 -> code=0.
  - With MSB_PRIO=0, req=8'b0010_1100 -> code=2.
- Zero word: req=0 -> zero=1, code=0, out_valid=1, enc_cnt increments by 1.
- Backpressure:
  - Accept req=8'h80, then out_ready=0 for 3 cycles -> code=7 held, in_ready=0, a second req is not accepted.
  - out_ready=1 with in_valid=1, req=8'h04 -> same-cycle drain and accept, next cycle code=2, out_valid stays 1.
- Saturation: CNT_W=4, stream 20 words -> enc_cnt stops at 15.
- PENC_MULTIHOT_ERR_EN defined:
  - req=8'h18 -> err=1, code=4, err_cnt=1.
  - req=8'h10 -> err=0, err_cnt stays 1.
  - rst mid-hold -> err=0, out_valid=0.
